// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, geometry defaults and derivations for the vga word fetcher
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      STREAM
   } fetch_state_t;

   localparam int DEF_H_TOTAL       = 800;
   localparam int DEF_V_TOTAL       = 525;
   localparam int DEF_BITMAP_HEIGHT = 384;

   // screen pixels covered by one memory word
   function automatic int calc_ppw(input int data_width, input int bits_per_pixel_x);
      return data_width << bits_per_pixel_x;
   endfunction

   function automatic int calc_wpr(input int bitmap_width, input int ppw);
      return bitmap_width / ppw;
   endfunction

endpackage

// File: rtl/vga_word_fetch_if.sv
// rtl/vga_word_fetch_if.sv - memory read port between the word fetcher and video memory
interface vga_word_fetch_if
   import vga_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
);
   logic                  mem_rd_req;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic                  mem_rd_gnt;
   logic                  mem_rd_valid;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   modport master (
      output mem_rd_req,
      output mem_rd_addr,
      input  mem_rd_gnt,
      input  mem_rd_valid,
      input  mem_rd_data
   );

   modport slave (
      input  mem_rd_req,
      input  mem_rd_addr,
      output mem_rd_gnt,
      output mem_rd_valid,
      output mem_rd_data
   );
endinterface

// File: rtl/word_fifo2.sv
// rtl/word_fifo2.sv - two-entry word prefetch buffer with simultaneous push/pop
module word_fifo2
   import vga_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  CLK_50,
   input  logic                  RESET_N,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            count
);
   logic [DATA_WIDTH-1:0] mem [2];
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge CLK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end
endmodule

// File: rtl/vga_word_fetch.sv
// rtl/vga_word_fetch.sv - raster-ahead bitmap word fetcher for the vga block
// VGA_FETCH_UNDERRUN_CNT_EN builds the saturating underrun counter; otherwise it reads 0.
module vga_word_fetch
   import vga_pkg::*;
#(
   parameter int DATA_WIDTH              = 16,
   parameter int ADDR_WIDTH              = 12,
   parameter int BITS_PER_MEMORY_PIXEL_X = 3,
   parameter int BITS_PER_MEMORY_PIXEL_Y = 4,
   parameter int HEX_START_X             = 512,
   parameter int BITMAP_HEIGHT           = DEF_BITMAP_HEIGHT,
   parameter int H_TOTAL                 = DEF_H_TOTAL,
   parameter int V_TOTAL                 = DEF_V_TOTAL,
   parameter int BASE_ADDR               = 0
) (
   input  logic                  CLK_50,
   input  logic                  RESET_N,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   vga_word_fetch_if.master      mem,
   output logic [DATA_WIDTH-1:0] pixel_in,
   output logic                  underrun,
   output logic [15:0]           underrun_count
);
   localparam int PPW = calc_ppw(DATA_WIDTH, BITS_PER_MEMORY_PIXEL_X);
   localparam int WPR = calc_wpr(HEX_START_X, PPW);
   localparam int CW  = $clog2(WPR) + 1;

   localparam logic [9:0]    X_START  = 10'(HEX_START_X);
   localparam logic [9:0]    X_CLR    = 10'(HEX_START_X - 1);
   localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]    Y_HEIGHT = 10'(BITMAP_HEIGHT);
   localparam logic [9:0]    PPW10    = 10'(PPW);
   localparam logic [CW-1:0] LAST_COL = CW'(WPR - 1);

   fetch_state_t          state;
   logic [CW-1:0]         col_idx;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic [ADDR_WIDTH-1:0] new_addr;
   logic [ADDR_WIDTH-1:0] cand_addr;
   logic                  fetch_pend;
   logic                  new_fetch;
   logic                  cand_valid;
   logic                  slot_ok;
   logic                  issue;
   logic                  col_load;
   logic                  empty_at_load;
   logic                  pop;
   logic                  push;
   logic                  granted;
   logic                  returned;
   logic                  drop_inc;
   logic                  drop_dec;
   logic [1:0]            outstanding;
   logic [1:0]            drop_cnt;
   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic [9:0]            next_line;
   logic [9:0]            load_x;

   assign next_line = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
   // column 0 loads at the end of the previous line so pixel_in never lags pixel_x
   assign load_x    = (col_idx == '0) ? X_LAST : 10'(col_idx) * PPW10 - 10'd1;

   assign col_load      = (state == STREAM) && (pixel_x == load_x);
   assign empty_at_load = col_load && (fifo_count == 2'd0);
   assign pop           = col_load && (fifo_count != 2'd0);
   assign new_fetch     = (state == PRIME) || (col_load && (col_idx != LAST_COL));
   assign new_addr      = (state == PRIME) ? row_base
                                           : row_base + ADDR_WIDTH'(col_idx) + ADDR_WIDTH'(1);

   // an unissued fetch for a skipped column is simply abandoned instead of dropped later
   assign cand_valid = (fetch_pend && !empty_at_load) || new_fetch;
   assign cand_addr  = new_fetch ? new_addr : fetch_addr;
   assign slot_ok    = ({1'b0, fifo_count} + {1'b0, outstanding}) < (3'd2 + {2'b0, pop});
   assign issue      = !mem.mem_rd_req && cand_valid && slot_ok;

   assign granted  = mem.mem_rd_req && mem.mem_rd_gnt;
   assign returned = mem.mem_rd_valid && (outstanding != 2'd0);
   assign drop_inc = empty_at_load && !fetch_pend;
   assign drop_dec = returned && (drop_cnt != 2'd0);
   assign push     = returned && (drop_cnt == 2'd0);

   word_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .CLK_50    (CLK_50),
      .RESET_N   (RESET_N),
      .push      (push),
      .push_data (mem.mem_rd_data),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge CLK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state           <= IDLE;
         col_idx         <= '0;
         row_base        <= '0;
         fetch_pend      <= 1'b0;
         fetch_addr      <= '0;
         mem.mem_rd_req  <= 1'b0;
         mem.mem_rd_addr <= '0;
         outstanding     <= 2'd0;
         drop_cnt        <= 2'd0;
         pixel_in        <= '0;
         underrun        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((pixel_x == X_START) && (next_line < Y_HEIGHT)) begin
                  state    <= PRIME;
                  row_base <= ADDR_WIDTH'(BASE_ADDR)
                            + ADDR_WIDTH'(next_line >> BITS_PER_MEMORY_PIXEL_Y) * ADDR_WIDTH'(WPR);
               end
            end
            PRIME: begin
               state   <= STREAM;
               col_idx <= '0;
            end
            STREAM: begin
               if (col_load) begin
                  col_idx <= col_idx + CW'(1);
                  if (col_idx == LAST_COL) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (col_load) begin
            pixel_in <= pop ? fifo_head : '0;
         end else if (pixel_x == X_CLR) begin
            pixel_in <= '0;
         end
         if (empty_at_load) underrun <= 1'b1;

         drop_cnt    <= drop_cnt + 2'(drop_inc) - 2'(drop_dec);
         outstanding <= outstanding + 2'(granted) - 2'(returned);

         fetch_pend <= cand_valid && !issue;
         if (cand_valid) fetch_addr <= cand_addr;
         if (issue) begin
            mem.mem_rd_req  <= 1'b1;
            mem.mem_rd_addr <= cand_addr;
         end else if (mem.mem_rd_gnt) begin
            mem.mem_rd_req  <= 1'b0;
         end
      end
   end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
   logic [15:0] cnt;

   always_ff @(posedge CLK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt <= 16'd0;
      end else if (empty_at_load && (cnt != 16'hFFFF)) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign underrun_count = cnt;
`else
   assign underrun_count = 16'd0;
`endif
endmodule
